text_cursor_ctrl: RTL and testbench
===================================

TEXT_CURSOR_CTRL -- requirements
Module: text_cursor_ctrl

Interface
REQ-001 SHALL have parameter CH_COLS, default 106, meaning text columns per row.
REQ-002 SHALL have parameter CH_ROWS, default 40, meaning text rows per screen.
REQ-003 SHALL have parameter FILL_CHAR, default 8'd32, meaning the code written by all clear operations.
REQ-004 SHALL have port write_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port tc_ch_in  input  8  character or control code from the requester.
REQ-007 SHALL have port tc_ch_valid  input  1  tc_ch_in is valid.
REQ-008 SHALL have port tc_ch_ready  output  1  the block accepts tc_ch_in this cycle.
REQ-009 SHALL have port tc_clear  input  1  full-screen clear request, level-sampled in IDLE.
REQ-010 SHALL have port tc_busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port vm_wr_addr  output  13  video memory character address.
REQ-012 SHALL have port vm_wr_data  output  8  character code to write.
REQ-013 SHALL have port vm_wr_en  output  1  write strobe, one write per high cycle.
REQ-014 SHALL have ports tc_cur_x  output  7 and tc_cur_y  output  6  current cursor column and row.

Function
REQ-015 SHALL implement states IDLE, WRITE, CLEAR_LINE and CLEAR_ALL.
REQ-016 SHALL drive tc_ch_ready = (state==IDLE) && !tc_clear; a transfer occurs on tc_ch_valid && tc_ch_ready.
REQ-017 SHALL give tc_clear priority over tc_ch_valid in IDLE; the character is not accepted that cycle.
REQ-018 SHALL register vm_wr_addr, vm_wr_data and vm_wr_en; vm_wr_addr = cur_y*CH_COLS + cur_x, computed at full width and truncated to 13 bits.
REQ-019 SHALL, for a printable code (any code other than 0x08, 0x0A, 0x0C, 0x0D) accepted in cycle N, assert vm_wr_en in cycle N+1 with data = code at the cursor address, then advance the cursor.
REQ-020 SHALL advance the cursor as follows: x+1 if x<CH_COLS-1, otherwise x=0 and a line advance.
REQ-021 SHALL perform a line advance as y+1, or y=0 when y==CH_ROWS-1, then enter CLEAR_LINE for the new row.
REQ-022 SHALL, in CLEAR_LINE, issue exactly CH_COLS consecutive writes of FILL_CHAR at ascending addresses row*CH_COLS .. row*CH_COLS+CH_COLS-1, then return to IDLE.
REQ-023 SHALL treat 0x0A (LF) as x=0 plus a line advance, with no character write.
REQ-024 SHALL treat 0x0D (CR) as x=0, with no write, and return to IDLE the next cycle.
REQ-025 SHALL treat 0x08 (BS) at x>0 as x-1 plus one FILL_CHAR write at the new position; BS at x==0 SHALL be a no-op.
REQ-026 SHALL treat 0x0C (FF) and tc_clear identically: enter CLEAR_ALL, issue CH_COLS*CH_ROWS writes of FILL_CHAR at addresses 0 upward, one per cycle, then set the cursor to (0,0) and return to IDLE.
REQ-027 SHALL hold tc_ch_ready low for the whole of WRITE, CLEAR_LINE and CLEAR_ALL; tc_clear raised during these states SHALL be ignored.
REQ-028 SHALL update tc_cur_x and tc_cur_y only when an operation completes; they are stable during clears.

Reset
REQ-029 SHALL, while rst_n is low at a clock edge, set state=IDLE, cursor=(0,0), vm_wr_en=0, vm_wr_addr=0, vm_wr_data=0, tc_busy=0; tc_ch_ready is low while rst_n is low.
REQ-030 SHALL, on reset during any clear, abort it with no further vm_wr_en pulses after the reset edge.

Structure
REQ-031 SHALL place CH_COLS/CH_ROWS defaults, FILL_CHAR, the control-code constants and the state encoding in the shared video package used with the video memory.
REQ-032 SHALL implement the run-of-writes counter (start address, length, busy/done) as a single sub-module, tc_fill_engine, shared by CLEAR_LINE, CLEAR_ALL and the BS clear.

Verification
REQ-033 Reset, then send 'A' (0x41) -> one vm_wr_en cycle with addr 0, data 0x41; cursor becomes (1,0).
REQ-034 Cursor at (105,0), send 0x42 -> write at addr 105; cursor (0,1); then 106 FILL_CHAR writes at addr 106..211; ready low throughout.
REQ-035 Cursor at (5,39), send 0x0A -> no character write; row 0 cleared at addr 0..105; cursor (0,0).
REQ-036 tc_clear and tc_ch_valid both high in IDLE -> char not accepted; 4240 writes at addr 0..4239; cursor (0,0); tc_busy high for the whole clear.
REQ-037 Send BS at (3,2), then BS at (0,2) -> first: write 0x20 at addr 214 with cursor (2,2); second: no write and cursor unchanged.
REQ-038 Assert rst_n low at the 100th write of CLEAR_ALL -> no vm_wr_en after the reset edge; cursor (0,0); ready high one cycle after rst_n returns high.

Source files
------------

// File: rtl/text_cursor_ctrl_pkg.sv
// Shared video package: screen geometry defaults, fill code, control codes,
// cursor controller state encoding and the character-cell address helper.
package text_cursor_ctrl_pkg;

  localparam int CH_COLS_DEF = 106;
  localparam int CH_ROWS_DEF = 40;
  localparam logic [7:0] FILL_CHAR_DEF = 8'd32;
  localparam int VM_AW = 13;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR_LINE,
    ST_CLEAR_ALL
  } tc_state_e;

  // Row-major cell address, formed at full width and truncated to the bus.
  function automatic logic [VM_AW-1:0] cell_addr(input int row, input int col, input int cols);
    int full;
    full = row * cols + col;
    return full[VM_AW-1:0];
  endfunction

  function automatic logic is_ctrl(input logic [7:0] code);
    return (code == CC_BS) || (code == CC_LF) || (code == CC_FF) || (code == CC_CR);
  endfunction

endpackage

// File: rtl/text_cursor_ctrl_fill_engine.sv
// Run-of-writes generator: issues len consecutive addresses from start_addr,
// one per cycle while busy, and pulses done the cycle after the last one.
module tc_fill_engine
  import text_cursor_ctrl_pkg::*;
(
  input  logic             write_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VM_AW-1:0] start_addr,
  input  logic [VM_AW-1:0] len,
  output logic             busy,
  output logic [VM_AW-1:0] wr_addr,
  output logic             done
);

  localparam logic [VM_AW-1:0] ONE = 1;

  logic [VM_AW-1:0] rem_q;

  // len must be non-zero; start is only raised while the engine is idle.
  always_ff @(posedge write_clk) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      wr_addr <= '0;
      rem_q   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        wr_addr <= start_addr;
        rem_q   <= len;
      end else if (busy) begin
        wr_addr <= wr_addr + ONE;
        rem_q   <= rem_q - ONE;
        if (rem_q == ONE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Text cursor controller: turns a character/control stream into video memory
// writes, tracking the cursor and clearing lines or the whole screen.
module text_cursor_ctrl
  import text_cursor_ctrl_pkg::*;
#(
  parameter int         CH_COLS   = CH_COLS_DEF,
  parameter int         CH_ROWS   = CH_ROWS_DEF,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEF
) (
  input  logic        write_clk,
  input  logic        rst_n,
  input  logic [7:0]  tc_ch_in,
  input  logic        tc_ch_valid,
  output logic        tc_ch_ready,
  input  logic        tc_clear,
  output logic        tc_busy,
  output logic [12:0] vm_wr_addr,
  output logic [7:0]  vm_wr_data,
  output logic        vm_wr_en,
  output logic [6:0]  tc_cur_x,
  output logic [5:0]  tc_cur_y
);

  localparam logic [VM_AW-1:0] SCREEN_LEN = VM_AW'(CH_COLS * CH_ROWS);
  localparam logic [VM_AW-1:0] LINE_LEN   = VM_AW'(CH_COLS);
  localparam logic [6:0]       X_LAST     = 7'(CH_COLS - 1);
  localparam logic [5:0]       Y_LAST     = 6'(CH_ROWS - 1);

  tc_state_e        state_q, state_d;
  logic [6:0]       x_d;
  logic [5:0]       y_d, y_adv;
  logic [7:0]       ch_q;
  logic             accept;
  logic             eng_start, eng_busy, eng_done;
  logic [VM_AW-1:0] eng_addr0, eng_len, eng_addr;

  // Handshake: a code transfers on a cycle where tc_ch_valid && tc_ch_ready;
  // ready is only offered in IDLE with no clear request and reset released.
  assign tc_ch_ready = rst_n && (state_q == ST_IDLE) && !tc_clear;
  assign tc_busy     = (state_q != ST_IDLE);
  assign accept      = tc_ch_valid && tc_ch_ready;
  assign y_adv       = (tc_cur_y == Y_LAST) ? 6'd0 : tc_cur_y + 6'd1;

  always_comb begin
    state_d   = state_q;
    x_d       = tc_cur_x;
    y_d       = tc_cur_y;
    eng_start = 1'b0;
    eng_addr0 = '0;
    eng_len   = '0;
    case (state_q)
      ST_IDLE: begin
        if (tc_clear) begin
          eng_start = 1'b1;
          eng_len   = SCREEN_LEN;
          state_d   = ST_CLEAR_ALL;
        end else if (accept) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (ch_q == CC_CR) begin
          x_d = 7'd0;
        end else if (ch_q == CC_FF) begin
          eng_start = 1'b1;
          eng_len   = SCREEN_LEN;
          state_d   = ST_CLEAR_ALL;
        end else if (ch_q == CC_BS) begin
          // Erasing the cell left of the cursor is a one-cell clear run.
          if (tc_cur_x != 7'd0) begin
            x_d       = tc_cur_x - 7'd1;
            eng_start = 1'b1;
            eng_addr0 = cell_addr(32'(tc_cur_y), 32'(tc_cur_x - 7'd1), CH_COLS);
            eng_len   = VM_AW'(1);
            state_d   = ST_CLEAR_LINE;
          end
        end else if ((ch_q != CC_LF) && (tc_cur_x < X_LAST)) begin
          x_d = tc_cur_x + 7'd1;
        end else begin
          x_d       = 7'd0;
          y_d       = y_adv;
          eng_start = 1'b1;
          eng_addr0 = cell_addr(32'(y_adv), 0, CH_COLS);
          eng_len   = LINE_LEN;
          state_d   = ST_CLEAR_LINE;
        end
      end
      ST_CLEAR_LINE: begin
        if (eng_done) state_d = ST_IDLE;
      end
      ST_CLEAR_ALL: begin
        if (eng_done) begin
          x_d     = 7'd0;
          y_d     = 6'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tc_cur_x   <= 7'd0;
      tc_cur_y   <= 6'd0;
      ch_q       <= 8'd0;
      vm_wr_en   <= 1'b0;
      vm_wr_addr <= '0;
      vm_wr_data <= 8'd0;
    end else begin
      state_q  <= state_d;
      tc_cur_x <= x_d;
      tc_cur_y <= y_d;
      vm_wr_en <= 1'b0;
      if (accept) ch_q <= tc_ch_in;
      if (eng_busy) begin
        vm_wr_en   <= 1'b1;
        vm_wr_addr <= eng_addr;
        vm_wr_data <= FILL_CHAR;
      end else if (accept && !is_ctrl(tc_ch_in)) begin
        vm_wr_en   <= 1'b1;
        vm_wr_addr <= cell_addr(32'(tc_cur_y), 32'(tc_cur_x), CH_COLS);
        vm_wr_data <= tc_ch_in;
      end
    end
  end

  tc_fill_engine u_fill (
    .write_clk  (write_clk),
    .rst_n      (rst_n),
    .start      (eng_start),
    .start_addr (eng_addr0),
    .len        (eng_len),
    .busy       (eng_busy),
    .wr_addr    (eng_addr),
    .done       (eng_done)
  );

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: character writes, wrap, LF/CR/BS/FF,
// full-screen clear priority and reset in the middle of a clear.
module tb_text_cursor_ctrl;

  logic        write_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tc_ch_in;
  logic        tc_ch_valid;
  logic        tc_ch_ready;
  logic        tc_clear;
  logic        tc_busy;
  logic [12:0] vm_wr_addr;
  logic [7:0]  vm_wr_data;
  logic        vm_wr_en;
  logic [6:0]  tc_cur_x;
  logic [5:0]  tc_cur_y;

  int          vectors = 0;
  int          miscompares = 0;
  logic [12:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wr_notbusy = 0;

  text_cursor_ctrl dut (
    .write_clk   (write_clk),
    .rst_n       (rst_n),
    .tc_ch_in    (tc_ch_in),
    .tc_ch_valid (tc_ch_valid),
    .tc_ch_ready (tc_ch_ready),
    .tc_clear    (tc_clear),
    .tc_busy     (tc_busy),
    .vm_wr_addr  (vm_wr_addr),
    .vm_wr_data  (vm_wr_data),
    .vm_wr_en    (vm_wr_en),
    .tc_cur_x    (tc_cur_x),
    .tc_cur_y    (tc_cur_y)
  );

  always #5 write_clk = ~write_clk;

  // Write log, sampled mid-cycle.
  always @(negedge write_clk) begin
    if (vm_wr_en) begin
      wa_q.push_back(vm_wr_addr);
      wd_q.push_back(vm_wr_data);
      if (!tc_busy) wr_notbusy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wr_notbusy = 0;
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    tc_ch_in    = c;
    tc_ch_valid = 1'b1;
    @(negedge write_clk);
    while (!tc_ch_ready && n < 10000) begin
      @(negedge write_clk);
      n++;
    end
    if (n == 10000) check("send_ready", tc_ch_ready, 1);
    @(posedge write_clk);
    #1;
    tc_ch_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (tc_busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, tc_busy, 0);
  endtask

  task automatic check_run(input string tag, input int first, input int n,
                           input int a0, input logic [7:0] d);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if ((first + i) >= wa_q.size()) bad++;
      else if (wa_q[first+i] !== 13'(a0 + i) || wd_q[first+i] !== d) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic check_cur(input string tag, input int x, input int y);
    check({tag, "_x"}, tc_cur_x, x);
    check({tag, "_y"}, tc_cur_y, y);
  endtask

  initial begin
    rst_n       = 1'b0;
    tc_ch_in    = 8'd0;
    tc_ch_valid = 1'b0;
    tc_clear    = 1'b0;

    // Reset state
    tick();
    check("rst_ready_low", tc_ch_ready, 0);
    tick();
    check("rst_wr_en", vm_wr_en, 0);
    check("rst_wr_addr", vm_wr_addr, 0);
    check("rst_wr_data", vm_wr_data, 0);
    check("rst_busy", tc_busy, 0);
    check_cur("rst_cur", 0, 0);
    rst_n = 1'b1;
    tick();
    check("rst_ready_high", tc_ch_ready, 1);

    // 'A' at (0,0): write visible the cycle after acceptance
    clear_log();
    send(8'h41);
    check("a_lat_en", vm_wr_en, 1);
    check("a_lat_addr", vm_wr_addr, 0);
    check("a_lat_data", vm_wr_data, 8'h41);
    wait_idle("a_idle", 10);
    check("a_nwr", wa_q.size(), 1);
    check_cur("a_cur", 1, 0);

    // Fill the rest of row 0 up to column 105
    clear_log();
    for (int i = 0; i < 104; i++) send(8'h61 + 8'(i % 26));
    wait_idle("row0_idle", 10);
    check("row0_nwr", wa_q.size(), 104);
    check_cur("row0_cur", 105, 0);

    // Wrap at the last column: char write then clear of row 1
    clear_log();
    send(8'h42);
    repeat (20) tick();
    check_cur("wrap_mid_cur", 0, 1);
    check("wrap_mid_ready", tc_ch_ready, 0);
    wait_idle("wrap_idle", 500);
    check("wrap_nwr", wa_q.size(), 107);
    check("wrap_c_addr", wa_q[0], 105);
    check("wrap_c_data", wd_q[0], 8'h42);
    check_run("wrap_run", 1, 106, 106, 8'h20);
    check("wrap_wr_notbusy", wr_notbusy, 0);
    check_cur("wrap_cur", 0, 1);

    // Reach (5,39), then LF wraps to row 0 and clears it
    for (int i = 0; i < 38; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    wait_idle("pos39_idle", 500);
    check_cur("pos39_cur", 5, 39);
    clear_log();
    send(8'h0A);
    wait_idle("lf_idle", 500);
    check("lf_nwr", wa_q.size(), 106);
    check_run("lf_run", 0, 106, 0, 8'h20);
    check_cur("lf_cur", 0, 0);

    // CR: no write, back to IDLE the next cycle
    for (int i = 0; i < 3; i++) send(8'h63);
    wait_idle("cr_pre_idle", 10);
    clear_log();
    send(8'h0D);
    check("cr_busy", tc_busy, 1);
    tick();
    check("cr_done", tc_busy, 0);
    check("cr_nwr", wa_q.size(), 0);
    check_cur("cr_cur", 0, 0);

    // BS at (3,2) then BS at (0,2)
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 3; i++) send(8'h64);
    wait_idle("bs_pre_idle", 500);
    check_cur("bs_pre_cur", 3, 2);
    clear_log();
    send(8'h08);
    wait_idle("bs1_idle", 20);
    check("bs1_nwr", wa_q.size(), 1);
    check_run("bs1_run", 0, 1, 214, 8'h20);
    check_cur("bs1_cur", 2, 2);
    send(8'h0D);
    wait_idle("bs_cr_idle", 10);
    clear_log();
    send(8'h08);
    wait_idle("bs2_idle", 20);
    check("bs2_nwr", wa_q.size(), 0);
    check_cur("bs2_cur", 0, 2);

    // tc_clear beats tc_ch_valid; clear requests during a clear are ignored
    send(8'h5A);
    wait_idle("clr_pre_idle", 10);
    clear_log();
    tc_clear    = 1'b1;
    tc_ch_valid = 1'b1;
    tc_ch_in    = 8'h41;
    @(negedge write_clk);
    check("clr_ready", tc_ch_ready, 0);
    @(posedge write_clk);
    #1;
    tc_clear    = 1'b0;
    tc_ch_valid = 1'b0;
    check("clr_busy", tc_busy, 1);
    repeat (100) tick();
    check_cur("clr_mid_cur", 1, 2);
    tc_clear = 1'b1;
    tick();
    tc_clear = 1'b0;
    wait_idle("clr_idle", 6000);
    check("clr_nwr", wa_q.size(), 4240);
    check_run("clr_run", 0, 4240, 0, 8'h20);
    check("clr_wr_notbusy", wr_notbusy, 0);
    check_cur("clr_cur", 0, 0);
    repeat (3) tick();
    check("clr_no_restart", tc_busy, 0);

    // FF clear aborted by reset on its 100th write
    send(8'h51);
    wait_idle("ff_pre_idle", 10);
    clear_log();
    send(8'h0C);
    begin
      int n = 0;
      while ((wa_q.size() + int'(vm_wr_en)) < 100 && n < 1000) begin
        tick();
        n++;
      end
    end
    check("ff_100th_en", vm_wr_en, 1);
    check("ff_100th_addr", vm_wr_addr, 99);
    check_cur("ff_mid_cur", 1, 0);
    rst_n = 1'b0;
    tick();
    check("ffrst_wr_en", vm_wr_en, 0);
    check("ffrst_ready", tc_ch_ready, 0);
    repeat (3) tick();
    check("ffrst_nwr", wa_q.size(), 100);
    check_run("ffrst_run", 0, 100, 0, 8'h20);
    check_cur("ffrst_cur", 0, 0);
    rst_n = 1'b1;
    tick();
    check("ffrel_ready", tc_ch_ready, 1);
    check("ffrel_busy", tc_busy, 0);
    repeat (5) tick();
    check("ffrel_nwr", wa_q.size(), 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
